// File: rtl/st_deframer.sv
// TDM receive deframer: qualifies f0 frame alignment (HUNT/CHECK/LOCK) and
// releases one parallel byte per channel, tagged with its channel number, while locked.
module st_deframer #(
  parameter int CH_NUM   = 32,
  parameter int MISS_MAX = 2
) (
  input  logic                      c4,
  input  logic                      rst,
  input  logic                      f0,
  input  logic                      clk_en1,
  input  logic                      sd,
  output logic [7:0]                data_out,
  output logic [$clog2(CH_NUM)-1:0] ch_out,
  output logic                      data_vld,
  output logic                      frame_start,
  output logic                      locked,
  output logic                      frame_err
);

  localparam int BPF = CH_NUM * 8;
  localparam int BW  = $clog2(BPF);
  localparam int MW  = $clog2(MISS_MAX + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BPF - 1);

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] LOCK  = 2'd2;

  logic          f0_q;
  logic          fe;
  logic [BW-1:0] bcnt_reg;
  logic          pend_reg;
  logic [6:0]    sh_reg;
  logic [1:0]    state_reg, state_next;
  logic [MW-1:0] miss_reg, miss_next;
  logic          err_next;

  logic [BW-1:0] samp_idx;
  logic [BW-1:0] bcnt_eff;
  logic          pend_eff;
  logic          wrap;
  logic          on_time;
  logic          byte_done;

  assign fe = ~f0 & f0_q;

  // pend_reg marks a realignment: the next enable samples bit 0 regardless of bcnt.
  assign samp_idx  = pend_reg ? '0 : ((bcnt_reg == LAST_BIT) ? '0 : bcnt_reg + BW'(1));
  assign wrap      = clk_en1 & ~pend_reg & (bcnt_reg == LAST_BIT);
  assign bcnt_eff  = clk_en1 ? samp_idx : bcnt_reg;
  assign pend_eff  = pend_reg & ~clk_en1;
  assign on_time   = fe & ~pend_eff & (bcnt_eff == LAST_BIT);
  assign byte_done = clk_en1 & (samp_idx[2:0] == 3'd7);

  always_comb begin
    state_next = state_reg;
    miss_next  = miss_reg;
    err_next   = 1'b0;
    case (state_reg)
      HUNT: begin
        if (fe) state_next = CHECK;
      end
      CHECK: begin
        if (fe) begin
          if (on_time) begin
            state_next = LOCK;
            miss_next  = '0;
          end
        end else if (wrap) begin
          state_next = HUNT;
        end
      end
      LOCK: begin
        if (fe && on_time) begin
          miss_next = '0;
        end else if (fe || wrap) begin
          err_next  = 1'b1;
          miss_next = miss_reg + MW'(1);
        end
        if (miss_next >= MW'(MISS_MAX)) state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge c4 or posedge rst) begin
    if (rst) begin
      f0_q      <= 1'b1;
      bcnt_reg  <= '0;
      pend_reg  <= 1'b0;
      sh_reg    <= '0;
      state_reg <= HUNT;
      miss_reg  <= '0;
    end else begin
      f0_q <= f0;
      if (clk_en1) begin
        sh_reg   <= {sh_reg[5:0], sd};
        bcnt_reg <= samp_idx;
        pend_reg <= 1'b0;
      end
      // The same-cycle enable has already finished the old bit; realign afterwards.
      if (fe) pend_reg <= 1'b1;
      state_reg <= state_next;
      miss_reg  <= miss_next;
    end
  end

  always_ff @(posedge c4 or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      ch_out      <= '0;
      data_vld    <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_vld    <= 1'b0;
      frame_start <= 1'b0;
      frame_err   <= err_next;
      locked      <= (state_reg == LOCK);
      // Gated on the current state, so a byte finishing on the exit cycle still goes out.
      if (state_reg == LOCK && byte_done) begin
        data_vld <= 1'b1;
        data_out <= {sh_reg, sd};
        ch_out   <= samp_idx[BW-1:3];
      end
      if (state_reg == LOCK && clk_en1 && samp_idx == '0) frame_start <= 1'b1;
    end
  end

endmodule

// File: tb/tb_st_deframer.sv
// Randomised and directed bench for st_deframer; a frame-level reference model
// (enable counts since alignment) predicts every output on every c4 cycle.
module tb_st_deframer;

  localparam int CH_NUM   = 32;
  localparam int MISS_MAX = 2;
  localparam int BPF      = CH_NUM * 8;
  localparam int PER      = 2 * BPF;

  logic       c4 = 1'b0;
  logic       rst;
  logic       f0;
  logic       clk_en1;
  logic       sd;
  logic [7:0] data_out;
  logic [4:0] ch_out;
  logic       data_vld;
  logic       frame_start;
  logic       locked;
  logic       frame_err;

  always #5 c4 = ~c4;

  st_deframer #(.CH_NUM(CH_NUM), .MISS_MAX(MISS_MAX)) dut (
    .c4          (c4),
    .rst         (rst),
    .f0          (f0),
    .clk_en1     (clk_en1),
    .sd          (sd),
    .data_out    (data_out),
    .ch_out      (ch_out),
    .data_vld    (data_vld),
    .frame_start (frame_start),
    .locked      (locked),
    .frame_err   (frame_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state 0=hunt 1=check 2=lock; m_cnt counts enables since alignment.
  int  m_state, m_miss, m_cnt, m_bits;
  bit  m_f0q;
  bit  e_vld, e_fs, e_err, e_lck;
  int  e_data, e_ch;

  task automatic model_reset();
    m_state = 0; m_miss = 0; m_cnt = 0; m_bits = 0; m_f0q = 1'b1;
    e_vld = 0; e_fs = 0; e_err = 0; e_lck = 0; e_data = 0; e_ch = 0;
  endtask

  task automatic model_step(input bit f, input bit e, input bit d);
    bit fe, wrap, on_time;
    int idx, nstate;
    fe    = !f && m_f0q;
    m_f0q = f;
    e_vld = 0; e_fs = 0; e_err = 0; wrap = 0;
    e_lck = (m_state == 2);
    if (e) begin
      idx    = m_cnt % BPF;
      wrap   = (m_cnt > 0) && (idx == 0);
      m_bits = ((m_bits << 1) | int'(d)) & 255;
      if (m_state == 2) begin
        if (idx % 8 == 7) begin
          e_vld = 1; e_data = m_bits; e_ch = idx / 8;
        end
        if (idx == 0) e_fs = 1;
      end
      m_cnt++;
    end
    on_time = fe && (m_cnt > 0) && (m_cnt % BPF == 0);
    if (fe) m_cnt = 0;
    nstate = m_state;
    case (m_state)
      0: if (fe) nstate = 1;
      1: begin
        if (fe) begin
          if (on_time) begin nstate = 2; m_miss = 0; end
        end else if (wrap) nstate = 0;
      end
      default: begin
        if (fe && on_time) m_miss = 0;
        else if (fe || wrap) begin e_err = 1; m_miss++; end
        if (m_miss >= MISS_MAX) nstate = 0;
      end
    endcase
    m_state = nstate;
  endtask

  int         cyc = 0;
  logic [7:0] chan [CH_NUM];
  bit         coll = 0;
  int         q_ch[$], q_dat[$], q_pos[$];
  int         n_err, n_fs;

  task automatic start_coll();
    q_ch.delete(); q_dat.delete(); q_pos.delete();
    n_err = 0; n_fs = 0; coll = 1;
  endtask

  task automatic tick(input bit f, input bit e, input bit d);
    f0 = f; clk_en1 = e; sd = d;
    @(posedge c4);
    model_step(f, e, d);
    @(negedge c4);
    chk("data_vld",    32'(data_vld),    32'(e_vld));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("frame_err",   32'(frame_err),   32'(e_err));
    chk("locked",      32'(locked),      32'(e_lck));
    chk("data_out",    32'(data_out),    32'(e_data));
    chk("ch_out",      32'(ch_out),      32'(e_ch));
    if (coll) begin
      if (data_vld) begin
        q_ch.push_back(int'(ch_out)); q_dat.push_back(int'(data_out)); q_pos.push_back(cyc % PER);
      end
      if (frame_err)   n_err++;
      if (frame_start) n_fs++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    f0 = 1'b1; clk_en1 = 1'b0; sd = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_data_out",    32'(data_out),    32'd0);
    chk("rst_ch_out",      32'(ch_out),      32'd0);
    chk("rst_data_vld",    32'(data_vld),    32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_locked",      32'(locked),      32'd0);
    chk("rst_frame_err",   32'(frame_err),   32'd0);
    model_reset();
    @(negedge c4);
    rst = 1'b0;
    cyc++;
  endtask

  // One frame period; enables on odd positions, bit k of the frame on position 2k+1.
  task automatic run_frame(input bit present, input int width, input int extra_pos, input int rst_pos);
    for (int p = 0; p < PER; p++) begin
      bit f, e, d;
      int k;
      f = !((present && p < width) || p == extra_pos);
      e = (p % 2 == 1);
      if (e) begin
        k = (p - 1) / 2;
        d = chan[k / 8][7 - (k % 8)];
      end else begin
        d = 1'($urandom_range(0, 1));
      end
      if (p == rst_pos) do_reset();
      else tick(f, e, d);
    end
    coll = 0;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < CH_NUM; i++) chan[i] = 8'(8'hA0 + i);
  endtask

  task automatic check_ramp(input string tag);
    chk({tag, "_vld_cnt"}, 32'(q_ch.size()), 32'(CH_NUM));
    for (int i = 0; i < q_ch.size(); i++) begin
      chk({tag, "_ch"},   32'(q_ch[i]),  32'(i));
      chk({tag, "_data"}, 32'(q_dat[i]), 32'(8'hA0 + i));
    end
  endtask

  initial begin
    int nz, nz_ch, nz_d, first_ch, r, w, x;
    rst = 1'b1; f0 = 1'b1; clk_en1 = 1'b0; sd = 1'b0;
    model_reset();
    repeat (3) @(negedge c4);
    chk("reset_data_out",    32'(data_out),    32'd0);
    chk("reset_ch_out",      32'(ch_out),      32'd0);
    chk("reset_data_vld",    32'(data_vld),    32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    chk("reset_locked",      32'(locked),      32'd0);
    chk("reset_frame_err",   32'(frame_err),   32'd0);
    rst = 1'b0;

    set_ramp();
    run_frame(1, 1, -1, -1);
    run_frame(1, 1, -1, -1);
    chk("lock_after_2fe", 32'(locked), 32'd1);
    start_coll(); run_frame(1, 1, -1, -1);
    check_ramp("nom");
    chk("nom_fs_cnt",  32'(n_fs),  32'd1);
    chk("nom_err_cnt", 32'(n_err), 32'd0);
    $display("nominal: bytes=%0d frame_starts=%0d", q_ch.size(), n_fs);

    for (int i = 0; i < CH_NUM; i++) chan[i] = 8'h00;
    chan[5] = 8'h81;
    start_coll(); run_frame(1, 1, -1, -1);
    nz = 0; nz_ch = -1; nz_d = -1;
    for (int i = 0; i < q_dat.size(); i++)
      if (q_dat[i] != 0) begin nz++; nz_ch = q_ch[i]; nz_d = q_dat[i]; end
    chk("bit_nz_cnt", 32'(nz),    32'd1);
    chk("bit_ch",     32'(nz_ch), 32'd5);
    chk("bit_data",   32'(nz_d),  32'h81);
    $display("bit order: nonzero bytes=%0d ch=%0d data=%0h", nz, nz_ch, nz_d);

    set_ramp();
    run_frame(1, 1, -1, -1);
    start_coll(); run_frame(0, 1, -1, -1);
    check_ramp("fw1");
    chk("fw1_err_cnt", 32'(n_err),  32'd1);
    chk("fw1_fs_cnt",  32'(n_fs),   32'd1);
    chk("fw1_locked",  32'(locked), 32'd1);
    $display("flywheel x1: bytes=%0d errs=%0d locked=%0b", q_ch.size(), n_err, locked);
    run_frame(1, 1, -1, -1);
    run_frame(0, 1, -1, -1);
    start_coll(); run_frame(0, 1, -1, -1);
    chk("fw2_vld_cnt", 32'(q_ch.size()), 32'd0);
    chk("fw2_locked",  32'(locked),      32'd0);
    $display("flywheel x2: bytes=%0d locked=%0b", q_ch.size(), locked);

    run_frame(1, 1, -1, -1);
    run_frame(1, 1, -1, -1);
    chk("relock", 32'(locked), 32'd1);
    start_coll(); run_frame(1, 1, 200, -1);
    first_ch = -1;
    for (int i = 0; i < q_pos.size(); i++)
      if (q_pos[i] > 200 && first_ch < 0) first_ch = q_ch[i];
    chk("mis_err_cnt",  32'(n_err),    32'd1);
    chk("mis_first_ch", 32'(first_ch), 32'd0);
    chk("mis_locked",   32'(locked),   32'd1);
    start_coll(); run_frame(1, 1, -1, -1);
    chk("mis_next_err",    32'(n_err),  32'd1);
    chk("mis_next_locked", 32'(locked), 32'd0);
    $display("misplaced: first ch after realign=%0d, locked after 2nd miss=%0b", first_ch, locked);

    run_frame(1, 3, -1, -1);
    run_frame(1, 3, -1, -1);
    start_coll(); run_frame(1, 3, -1, -1);
    check_ramp("long");
    chk("long_err_cnt", 32'(n_err),  32'd0);
    chk("long_locked",  32'(locked), 32'd1);
    $display("long f0: bytes=%0d errs=%0d", q_ch.size(), n_err);

    run_frame(1, 1, -1, 171);
    run_frame(1, 1, -1, -1);
    run_frame(1, 1, -1, -1);
    chk("rst_relock", 32'(locked), 32'd1);
    $display("reset mid-frame: relocked=%0b", locked);

    for (int fr = 0; fr < 16; fr++) begin
      for (int i = 0; i < CH_NUM; i++) chan[i] = 8'($urandom);
      r = $urandom_range(0, 9);
      w = 1; x = -1;
      if (r == 1) x = $urandom_range(2, PER - 1);
      if (r == 2) w = $urandom_range(2, 4);
      run_frame(r != 0, w, x, -1);
      $display("random frame %0d: kind=%0d locked=%0b", fr, r, locked);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
